// File: rtl/pe_seq.sv
// rtl/pe_seq.sv - job sequencer for a MAC PE: clear, slot-interleaved feed, drain, round
// Optional feature: define PE_SEQ_PERF_EN to add the perf_stall_cnt output.
module pe_seq #(
  parameter int DATA_W  = 16,
  parameter int NUM_ACC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [7:0]        cfg_acc_len,
  input  logic [3:0]        cfg_slots,
  input  logic [2:0]        cfg_conn,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] pe_data_in_1,
  output logic [DATA_W-1:0] pe_data_in_2,
  output logic [3:0]        pe_add_number,
  output logic [3:0]        pe_round_number,
  output logic              pe_rounder_en,
  output logic [2:0]        pe_connection_state,
  output logic              pe_acc_clr,
  output logic              res_valid,
  output logic [3:0]        res_slot,
  output logic              busy,
  output logic              done
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, ROUND, DONE} state_t;

  // Slot count is kept one bit wider than the 4-bit selects so NUM_ACC=16 still fits.
  localparam logic [4:0] SLOTS_MAX = 5'(NUM_ACC);

  state_t      r_state;
  logic [7:0]  r_len;
  logic [4:0]  r_slots;
  logic [2:0]  r_conn;
  logic [4:0]  r_s;
  logic [7:0]  r_k;
  logic [4:0]  r_r;
  logic        r_drain;
  logic        r_res_valid;
  logic [3:0]  r_res_slot;

  logic [4:0]  w_slots;
  logic        w_fire;
  logic        w_s_last;
  logic        w_k_last;
  logic        w_r_last;

  assign w_slots  = (cfg_slots == 4'd0 || {1'b0, cfg_slots} > SLOTS_MAX) ? SLOTS_MAX
                                                                        : {1'b0, cfg_slots};
  assign w_fire   = (r_state == FEED) && op_valid;
  assign w_s_last = (r_s == r_slots - 5'd1);
  assign w_k_last = (r_k == r_len - 8'd1);
  assign w_r_last = (r_r == r_slots - 5'd1);

  // Job sequencing: latch config, walk operands slot-major per pass, wait out the PE pipe, round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= 8'd0;
      r_slots <= 5'd0;
      r_conn  <= 3'd0;
      r_s     <= 5'd0;
      r_k     <= 8'd0;
      r_r     <= 5'd0;
      r_drain <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cfg_start) begin
            r_len   <= cfg_acc_len;
            r_slots <= w_slots;
            r_conn  <= cfg_conn;
            r_s     <= 5'd0;
            r_k     <= 8'd0;
            r_r     <= 5'd0;
            r_drain <= 1'b0;
            r_state <= (cfg_acc_len == 8'd0) ? DONE : CLR;
          end
        end
        CLR: r_state <= FEED;
        FEED: begin
          if (w_fire) begin
            if (w_s_last) begin
              r_s <= 5'd0;
              if (w_k_last) r_state <= DRAIN;
              else          r_k     <= r_k + 8'd1;
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        DRAIN: begin
          if (r_drain) begin
            r_drain <= 1'b0;
            r_state <= ROUND;
          end else begin
            r_drain <= 1'b1;
          end
        end
        ROUND: begin
          if (w_r_last) r_state <= DONE;
          else          r_r     <= r_r + 5'd1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The PE presents a rounded slot on data_out one cycle after its round strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_slot  <= 4'd0;
    end else begin
      r_res_valid <= (r_state == ROUND);
      r_res_slot  <= (r_state == ROUND) ? r_r[3:0] : 4'd0;
    end
  end

  assign op_ready            = (r_state == FEED);
  assign pe_data_in_1        = w_fire ? op_a : '0;
  assign pe_data_in_2        = w_fire ? op_b : '0;
  assign pe_add_number       = w_fire ? r_s[3:0] : 4'd0;
  assign pe_acc_clr          = (r_state == CLR);
  assign pe_rounder_en       = (r_state == ROUND);
  assign pe_round_number     = pe_rounder_en ? r_r[3:0] : 4'd0;
  assign busy                = (r_state != IDLE);
  assign pe_connection_state = busy ? r_conn : 3'd0;
  assign done                = (r_state == DONE);
  assign res_valid           = r_res_valid;
  assign res_slot            = r_res_slot;

`ifdef PE_SEQ_PERF_EN
  logic [15:0] r_stall_cnt;

  // Count FEED cycles starved of operands; saturates, and survives until the next job's clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (r_state == CLR) begin
      r_stall_cnt <= 16'd0;
    end else if (r_state == FEED && !op_valid && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pe_seq.sv
// tb/tb_pe_seq.sv - randomized self-checking bench for pe_seq against a job schedule model
`timescale 1ns/1ps
module tb_pe_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [7:0]  cfg_acc_len;
  logic [3:0]  cfg_slots;
  logic [2:0]  cfg_conn;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] pe_data_in_1;
  logic [15:0] pe_data_in_2;
  logic [3:0]  pe_add_number;
  logic [3:0]  pe_round_number;
  logic        pe_rounder_en;
  logic [2:0]  pe_connection_state;
  logic        pe_acc_clr;
  logic        res_valid;
  logic [3:0]  res_slot;
  logic        busy;
  logic        done;
`ifdef PE_SEQ_PERF_EN
  logic [15:0] perf_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_seq #(.DATA_W(16), .NUM_ACC(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cfg_start           (cfg_start),
    .cfg_acc_len         (cfg_acc_len),
    .cfg_slots           (cfg_slots),
    .cfg_conn            (cfg_conn),
    .op_valid            (op_valid),
    .op_ready            (op_ready),
    .op_a                (op_a),
    .op_b                (op_b),
    .pe_data_in_1        (pe_data_in_1),
    .pe_data_in_2        (pe_data_in_2),
    .pe_add_number       (pe_add_number),
    .pe_round_number     (pe_round_number),
    .pe_rounder_en       (pe_rounder_en),
    .pe_connection_state (pe_connection_state),
    .pe_acc_clr          (pe_acc_clr),
    .res_valid           (res_valid),
    .res_slot            (res_slot),
    .busy                (busy),
`ifdef PE_SEQ_PERF_EN
    .perf_stall_cnt      (perf_stall_cnt),
`endif
    .done                (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return 64'({op_ready, pe_data_in_1, pe_data_in_2, pe_add_number, pe_round_number,
                pe_rounder_en, pe_connection_state, pe_acc_clr, res_valid, res_slot,
                busy, done});
  endfunction

  // One job, cycle by cycle. Inputs change just after the falling edge; checks run 1ns later.
  // Expected schedule: CLR, then len*S handshakes with slot = issue_index mod S,
  // two drain cycles, S round cycles (results trail by one), DONE, IDLE.
  task automatic run_job(input int len, input int slots, input int conn, input int mode,
                         input bit restart, input int abort_at);
    int          s_used;
    int          total;
    int          issued;
    int          idle;
    int          cyc;
    logic        v;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  cn;
    s_used = (slots == 0 || slots > 8) ? 8 : slots;
    total  = len * s_used;
    cn     = 3'(conn);
    idle   = 0;

    cfg_start   = 1'b1;
    cfg_acc_len = 8'(len);
    cfg_slots   = 4'(slots);
    cfg_conn    = cn;
    op_valid    = 1'b0;
    #1;
    chk("start_in_idle", 64'(busy), 64'(0));
    @(negedge clk);
    cfg_start = 1'b0;

    if (len != 0) begin
      #1;
      chk("clr_pulse", 64'(pe_acc_clr), 64'(1));
      chk("clr_ready", 64'(op_ready), 64'(0));
      chk("clr_conn", 64'(pe_connection_state), 64'(cn));
      chk("clr_busy", 64'(busy), 64'(1));
      @(negedge clk);

      issued = 0;
      cyc    = 0;
      while (issued < total && cyc < 4000) begin
        case (mode)
          0, 3:    v = 1'b1;
          1:       v = (cyc % 2 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        a = (mode == 3) ? 16'h0200 : 16'($urandom);
        b = (mode == 3) ? 16'h0400 : 16'($urandom);
        op_valid = v;
        op_a     = a;
        op_b     = b;
        if (restart) begin
          cfg_start   = 1'b1;
          cfg_acc_len = 8'($urandom);
          cfg_slots   = 4'($urandom);
          cfg_conn    = ~cn;
        end
        if (abort_at > 0 && issued == abort_at) begin
          op_valid = 1'b1;
          #1;
          rst = 1'b1;
          #1;
          chk("rst_outputs_zero", all_out(), 64'(0));
          @(negedge clk);
          rst       = 1'b0;
          op_valid  = 1'b0;
          cfg_start = 1'b0;
          for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_idle", 64'({busy, done, pe_acc_clr, pe_rounder_en}), 64'(0));
            @(negedge clk);
          end
          return;
        end
        #1;
        chk("feed_ready", 64'(op_ready), 64'(1));
        chk("feed_clr", 64'(pe_acc_clr), 64'(0));
        chk("feed_done", 64'(done), 64'(0));
        chk("feed_conn", 64'(pe_connection_state), 64'(cn));
        if (v) begin
          chk("feed_data1", 64'(pe_data_in_1), 64'(a));
          chk("feed_data2", 64'(pe_data_in_2), 64'(b));
          chk("feed_slot", 64'(pe_add_number), 64'(issued % s_used));
          issued++;
        end else begin
          chk("stall_data_zero", 64'({pe_data_in_1, pe_data_in_2}), 64'(0));
          idle++;
        end
        cyc++;
        @(negedge clk);
      end
      chk("issue_count", 64'(issued), 64'(total));
      cfg_start = 1'b0;
      cfg_conn  = cn;
      if (issued != total) return;

      for (int d = 0; d < 2; d++) begin
        op_valid = 1'b1;
        #1;
        chk("drain_ready", 64'(op_ready), 64'(0));
        chk("drain_data_zero", 64'({pe_data_in_1, pe_data_in_2}), 64'(0));
        chk("drain_round", 64'(pe_rounder_en), 64'(0));
        chk("drain_res", 64'(res_valid), 64'(0));
        chk("drain_busy", 64'(busy), 64'(1));
        @(negedge clk);
      end
      op_valid = 1'b0;

      for (int r = 0; r < s_used; r++) begin
        #1;
        chk("round_en", 64'(pe_rounder_en), 64'(1));
        chk("round_num", 64'(pe_round_number), 64'(r));
        chk("round_res_valid", 64'(res_valid), 64'(r > 0));
        if (r > 0) chk("round_res_slot", 64'(res_slot), 64'(r - 1));
        chk("round_done", 64'(done), 64'(0));
        @(negedge clk);
      end
    end

    op_valid  = 1'b0;
    cfg_start = restart;
    #1;
    chk("done_pulse", 64'(done), 64'(1));
    chk("done_busy", 64'(busy), 64'(1));
    chk("done_clr", 64'(pe_acc_clr), 64'(0));
    chk("done_round", 64'(pe_rounder_en), 64'(0));
    chk("done_conn", 64'(pe_connection_state), 64'(cn));
    chk("done_res_valid", 64'(res_valid), 64'(len != 0));
    if (len != 0) chk("done_res_slot", 64'(res_slot), 64'(s_used - 1));
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
    chk("after_idle", 64'({busy, done, pe_connection_state, res_valid}), 64'(0));
`ifdef PE_SEQ_PERF_EN
    if (len != 0) chk("perf_stall", 64'(perf_stall_cnt), 64'(idle));
`endif
    @(negedge clk);
    #1;
    chk("idle_hold", 64'({busy, done}), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    cfg_start   = 1'b0;
    cfg_acc_len = 8'd0;
    cfg_slots   = 4'd0;
    cfg_conn    = 3'd0;
    op_valid    = 1'b0;
    op_a        = 16'd0;
    op_b        = 16'd0;
    #1;
    chk("reset_outputs_zero", all_out(), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_release_idle", 64'(busy), 64'(0));
    @(negedge clk);
    #1;
    chk("first_edge_idle", 64'({busy, done}), 64'(0));
    @(negedge clk);

    run_job(1, 1, 5, 3, 1'b0, 0);
    run_job(3, 8, 2, 0, 1'b0, 0);
    run_job(2, 3, 7, 1, 1'b0, 0);
    run_job(4, 0, 1, 2, 1'b0, 0);
    run_job(2, 12, 3, 0, 1'b0, 0);
    run_job(0, 4, 6, 0, 1'b0, 0);
    run_job(3, 5, 4, 2, 1'b1, 0);
    run_job(0, 2, 1, 0, 1'b1, 0);
    run_job(4, 4, 6, 0, 1'b0, 5);
    run_job(2, 6, 5, 2, 1'b0, 0);
    for (int j = 0; j < 3; j++) begin
      run_job(int'($urandom_range(1, 4)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 7)), 2, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
